// File: rtl/dma_burst_pkg.sv
// rtl/dma_burst_pkg.sv - shared constants and FSM state type for the burst read DMA engine
package dma_burst_pkg;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_SRC  = 4'h4;
  localparam logic [3:0] REG_LEN  = 4'h8;
  localparam logic [3:0] REG_HITS = 4'hC;

  localparam int CTRL_START    = 0;
  localparam int CTRL_BUSY     = 1;
  localparam int CTRL_DONE     = 2;
  localparam int CTRL_IRQ_MASK = 3;

  localparam logic [8:0] SDRAM_WIN = 9'hF0;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} dma_state_e;

endpackage

// File: rtl/dma_sfifo.sv
// rtl/dma_sfifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module dma_sfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;

  assign do_pop    = pop_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  // Storage has no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_burst_reader.sv
// rtl/dma_burst_reader.sv - register-programmed single-word read DMA into the SDRAM window
// Optional DMA_IRQ_EN adds CTRL bit3 IRQ_MASK and drives irq_o = DONE & IRQ_MASK.
module dma_burst_reader
  import dma_burst_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_cyc_i,
  input  logic        cfg_stb_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_adr_i,
  input  logic [31:0] cfg_dat_i,
  output logic [31:0] cfg_dat_o,
  output logic        cfg_ack_o,
  output logic        dma_wbs_cyc_o,
  output logic        dma_wbs_stb_o,
  output logic        dma_wbs_we_o,
  output logic [31:0] dma_wbs_adr_o,
  input  logic [31:0] dma_wbs_dat_i,
  input  logic        dma_wbs_ack_i,
  input  logic        dma_brust_valid_i,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        irq_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  dma_state_e         state_q, state_d;
  logic [22:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [22:0]        src_q, src_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        hits_q, hits_d;
  logic               done_q, done_d;
  logic               cfg_ack_q, cfg_ack_d;
  logic [31:0]        cfg_dat_q, cfg_dat_d;
  logic               mask_rd;

  logic               cfg_req, cfg_wr, start;
  logic               fetch_en, bus_ack, pop, drain_done;
  logic [32:0]        fifo_wdata, fifo_rdata;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_dat_i;

  // A held request acks once: the ack register blocks re-entry on the following cycle.
  assign cfg_req = cfg_cyc_i && cfg_stb_i && !cfg_ack_q;
  assign cfg_wr  = cfg_req && cfg_we_i;
  assign start   = cfg_wr && (cfg_adr_i == REG_CTRL) && cfg_dat_i[CTRL_START];

  // Only request when the returning word is guaranteed a FIFO slot.
  assign fetch_en   = (state_q == REQ) && (fifo_count < DEPTH_C);
  assign bus_ack    = fetch_en && dma_wbs_ack_i;
  assign pop        = m_tvalid && m_tready;
  assign drain_done = (fifo_count == '0) || ((fifo_count == CNT_ONE) && pop);
  assign fifo_wdata = {rem_q == LEN_ONE, dma_wbs_dat_i};

  dma_sfifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_i      (bus_ack),
    .push_data_i (fifo_wdata),
    .pop_i       (pop),
    .rd_data_o   (fifo_rdata),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef DMA_IRQ_EN
  logic mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (cfg_wr && (cfg_adr_i == REG_CTRL)) begin
      mask_d = cfg_dat_i[CTRL_IRQ_MASK];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mask_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_rd = mask_q;
  assign irq_o   = done_q && mask_q;
`else
  assign mask_rd = 1'b0;
  assign irq_o   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    src_d     = src_q;
    len_d     = len_q;
    hits_d    = hits_q;
    done_d    = done_q;
    cfg_ack_d = cfg_req;
    cfg_dat_d = 32'd0;

    if (cfg_req && !cfg_we_i) begin
      case (cfg_adr_i)
        REG_CTRL: cfg_dat_d = {28'd0, mask_rd, done_q, state_q != IDLE, 1'b0};
        REG_SRC:  cfg_dat_d = 32'(src_q);
        REG_LEN:  cfg_dat_d = 32'(len_q);
        REG_HITS: cfg_dat_d = hits_q;
        default:  cfg_dat_d = 32'd0;
      endcase
    end

    if (cfg_wr) begin
      case (cfg_adr_i)
        REG_CTRL: if (cfg_dat_i[CTRL_DONE]) done_d = 1'b0;
        REG_SRC:  src_d = {cfg_dat_i[22:2], 2'b00};
        REG_LEN:  len_d = cfg_dat_i[LEN_W-1:0];
        default:  ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_q != '0) begin
            addr_d  = src_q;
            rem_d   = len_q;
            done_d  = 1'b0;
            hits_d  = 32'd0;
            state_d = REQ;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          addr_d = addr_q + 23'd4;
          rem_d  = rem_q - LEN_ONE;
          if (dma_brust_valid_i && (hits_q != '1)) begin
            hits_d = hits_q + 32'd1;
          end
          state_d = (rem_q == LEN_ONE) ? DRAIN : GAP;
        end
      end
      GAP:   state_d = REQ;
      DRAIN: begin
        if (drain_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      src_q     <= '0;
      len_q     <= '0;
      hits_q    <= '0;
      done_q    <= 1'b0;
      cfg_ack_q <= 1'b0;
      cfg_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      src_q     <= src_d;
      len_q     <= len_d;
      hits_q    <= hits_d;
      done_q    <= done_d;
      cfg_ack_q <= cfg_ack_d;
      cfg_dat_q <= cfg_dat_d;
    end
  end

  assign cfg_ack_o     = cfg_ack_q;
  assign cfg_dat_o     = cfg_dat_q;
  assign dma_wbs_cyc_o = fetch_en;
  assign dma_wbs_stb_o = fetch_en;
  assign dma_wbs_we_o  = 1'b0;
  assign dma_wbs_adr_o = fetch_en ? {SDRAM_WIN, addr_q} : 32'd0;
  assign m_tvalid      = !fifo_empty;
  assign m_tdata       = fifo_empty ? 32'd0 : fifo_rdata[31:0];
  assign m_tlast       = !fifo_empty && fifo_rdata[32];

endmodule

// File: tb/tb_dma_burst_reader.sv
// tb/tb_dma_burst_reader.sv - randomized self-checking bench for dma_burst_reader
module tb_dma_burst_reader;

  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W      = 16;
`ifdef DMA_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_cyc = 0, cfg_stb = 0, cfg_we = 0;
  logic [3:0]  cfg_adr = 0;
  logic [31:0] cfg_wdat = 0;
  logic [31:0] cfg_rdat;
  logic        cfg_ack;
  logic        dma_cyc, dma_stb, dma_we;
  logic [31:0] dma_adr;
  logic [31:0] dma_dat = 0;
  logic        dma_ack = 0, dma_brust = 0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 0;
  logic        irq;

  int          checks = 0, errors = 0;
  logic [31:0] salt = 0;
  logic [31:0] hit_pat = 0;
  int          slave_lat = 0, lat_cnt = 0, ack_idx = 0, gap_err = 0, cyc_cycles = 0;
  bit          ack_prev = 0, rand_rdy = 0;
  logic [31:0] adr_log[$];
  logic [31:0] rx_data[$];
  logic        rx_last[$];

  dma_burst_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .cfg_cyc_i         (cfg_cyc),
    .cfg_stb_i         (cfg_stb),
    .cfg_we_i          (cfg_we),
    .cfg_adr_i         (cfg_adr),
    .cfg_dat_i         (cfg_wdat),
    .cfg_dat_o         (cfg_rdat),
    .cfg_ack_o         (cfg_ack),
    .dma_wbs_cyc_o     (dma_cyc),
    .dma_wbs_stb_o     (dma_stb),
    .dma_wbs_we_o      (dma_we),
    .dma_wbs_adr_o     (dma_adr),
    .dma_wbs_dat_i     (dma_dat),
    .dma_wbs_ack_i     (dma_ack),
    .dma_brust_valid_i (dma_brust),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tlast           (m_tlast),
    .m_tready          (m_tready),
    .irq_o             (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // SDRAM slave: fixed latency, data is a pure function of the address.
  always @(negedge clk) begin
    if (dma_cyc) cyc_cycles++;
    if (dma_stb && ack_prev) gap_err++;
    if (dma_ack) begin
      dma_ack = 0; dma_brust = 0; dma_dat = 0; lat_cnt = 0;
    end else if (dma_stb) begin
      if (lat_cnt >= slave_lat) begin
        dma_ack   = 1;
        dma_dat   = mem_word(dma_adr);
        dma_brust = hit_pat[ack_idx % 32];
        adr_log.push_back(dma_adr);
        ack_idx++;
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
    ack_prev = dma_ack;
  end

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      rx_data.push_back(m_tdata);
      rx_last.push_back(m_tlast);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n = 0;
    cfg_cyc = 1; cfg_stb = 1; cfg_we = we; cfg_adr = adr; cfg_wdat = wd;
    do begin
      tick();
      n++;
    end while (!cfg_ack && n < 8);
    rd = cfg_rdat;
    if (!cfg_ack) chk("cfg_ack_timeout", {31'd0, cfg_ack}, 32'd1);
    cfg_cyc = 0; cfg_stb = 0; cfg_we = 0;
  endtask

  task automatic cfg_wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    cfg_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic cfg_rd(input logic [3:0] adr, output logic [31:0] rd);
    cfg_xfer(1'b0, adr, 32'd0, rd);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] src, input int len, input int lat,
                          input bit rnd, input bit hold, input logic [31:0] ctrl_base);
    logic [31:0] rd, exp_adr;
    logic [22:0] a23;
    int n, exp_hits;
    adr_log.delete(); rx_data.delete(); rx_last.delete();
    ack_idx = 0; gap_err = 0; slave_lat = lat;
    rand_rdy = 0; m_tready = !hold;
    cfg_wr(4'h4, src);
    cfg_wr(4'h8, 32'(len));
    cfg_wr(4'h0, ctrl_base | 32'h1);
    chk({tag, "_start_stb"}, {31'd0, dma_stb}, 32'd1);
    if (hold) begin
      repeat (60) tick();
      chk({tag, "_bp_acks"}, 32'(adr_log.size()), 32'(FIFO_DEPTH));
      chk({tag, "_bp_stb"}, {31'd0, dma_stb}, 32'd0);
      m_tready = 1;
    end
    rand_rdy = rnd;
    n = 0;
    while (rx_data.size() < len && n < 3000) begin
      tick();
      n++;
    end
    rand_rdy = 0; m_tready = 1;
    tick(); tick();
    chk({tag, "_words"}, 32'(rx_data.size()), 32'(len));
    chk({tag, "_reqs"}, 32'(adr_log.size()), 32'(len));
    exp_hits = 0;
    for (int i = 0; i < len; i++) begin
      a23 = src[22:0] + 23'(4 * i);
      a23[1:0] = 2'b00;
      exp_adr = {9'hF0, a23};
      if (hit_pat[i % 32]) exp_hits++;
      if (i < adr_log.size()) chk({tag, "_adr"}, adr_log[i], exp_adr);
      if (i < rx_data.size()) begin
        chk({tag, "_data"}, rx_data[i], mem_word(exp_adr));
        chk({tag, "_last"}, {31'd0, rx_last[i]}, {31'd0, i == len - 1});
      end
    end
    chk({tag, "_gap"}, 32'(gap_err), 32'd0);
    cfg_rd(4'h0, rd);
    chk({tag, "_ctrl"}, rd, 32'h4 | (ctrl_base & {28'd0, IRQ_EN, 3'b000}));
    cfg_rd(4'hC, rd);
    chk({tag, "_hits"}, rd, 32'(exp_hits));
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, IRQ_EN & ctrl_base[3]});
  endtask

  initial begin
    logic [31:0] rd;
    int cyc0, n;
    repeat (3) tick();
    chk("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    chk("rst_bus", {dma_cyc, dma_stb, dma_we, m_tvalid, m_tlast, irq}, 32'd0);
    chk("rst_adr", dma_adr, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    rst = 0;
    tick();
    cfg_rd(4'h0, rd); chk("rst_ctrl", rd, 32'd0);
    cfg_rd(4'h4, rd); chk("rst_src", rd, 32'd0);
    cfg_rd(4'h8, rd); chk("rst_len", rd, 32'd0);
    cfg_rd(4'hC, rd); chk("rst_hits", rd, 32'd0);
    tick();
    chk("cfg_ack_pulse", {31'd0, cfg_ack}, 32'd0);

    salt = $urandom;
    hit_pat = 32'h0;
    run_xfer("basic", 32'h100, 4, 2, 0, 0, 32'h0);
    hit_pat = $urandom;
    run_xfer("bp", {$urandom} & 32'h7F_FFFC, 12, 1, 0, 1, 32'h0);
    run_xfer("wrap", 32'h7F_FFFC, 2, 0, 0, 0, 32'h0);

    cfg_wr(4'h0, 32'h4);
    cfg_rd(4'h0, rd); chk("done_w1c", rd, 32'h0);
    cfg_rd(4'h2, rd); chk("unmapped", rd, 32'h0);
    cyc0 = cyc_cycles;
    cfg_wr(4'h8, 32'h0);
    cfg_wr(4'h0, 32'h1);
    chk("len0_stb", {31'd0, dma_stb}, 32'd0);
    cfg_rd(4'h0, rd); chk("len0_done", rd, 32'h4);
    repeat (4) tick();
    chk("len0_nocyc", 32'(cyc_cycles - cyc0), 32'd0);

    // Reset while the third fetch is pending.
    hit_pat = 32'hFFFF_FFFF;
    adr_log.delete(); slave_lat = 3; m_tready = 1;
    cfg_wr(4'h4, 32'h2000);
    cfg_wr(4'h8, 32'd5);
    cfg_wr(4'h0, 32'h1);
    n = 0;
    while (!(adr_log.size() == 2 && dma_stb) && n < 200) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", 32'(adr_log.size()), 32'd2);
    rst = 1;
    tick();
    chk("rst_mid_bus", {29'd0, dma_cyc, dma_stb, m_tvalid}, 32'd0);
    rst = 0;
    tick(); tick();
    cfg_rd(4'h0, rd); chk("rst_mid_ctrl", rd, 32'h0);
    cfg_rd(4'hC, rd); chk("rst_mid_hits", rd, 32'h0);
    cfg_rd(4'h8, rd); chk("rst_mid_len", rd, 32'h0);
    run_xfer("after_rst", 32'h40, 5, 1, 0, 0, 32'h0);

    hit_pat = 32'h2A;
    run_xfer("hits", 32'h1230, 6, 1, 0, 0, 32'h8);
`ifdef DMA_IRQ_EN
    cfg_wr(4'h0, 32'hC);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    cfg_rd(4'h0, rd); chk("irq_mask_rd", rd, 32'h8);
`else
    cfg_wr(4'h0, 32'hC);
    cfg_rd(4'h0, rd); chk("mask_absent", rd, 32'h0);
`endif

    for (int k = 0; k < 6; k++) begin
      hit_pat = $urandom;
      run_xfer("rand", ($urandom_range(0, 3) == 0) ? 32'h7F_FFF0 : {$urandom} & 32'h7F_FFFC,
               $urandom_range(1, 20), $urandom_range(0, 3), 1, 0, 32'(k % 2) << 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_burst_reader.md
# dma_burst_reader

Wishbone-configured read DMA engine upstream of the SDRAM user project. It issues single-word reads on the DMA Wishbone port inside the SDRAM window (adr[31:23] = 9'hF0, base 0x7800_0000). It buffers the returned words in a small FIFO and streams them out on a valid/ready interface. The CPU programs source, length and start through a small slave register file and polls or takes an interrupt on completion.

## Interface
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥2.
- LEN_W, 16: width of the transfer-length register, in words.
- wb_clk_i  in  1  single clock; all logic rises on posedge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cfg_cyc_i, cfg_stb_i, cfg_we_i  in  1 each  CPU slave strobe/cycle/write.
- cfg_adr_i  in  4  byte offset into the register file.
- cfg_dat_i  in  32  write data.
- cfg_dat_o  out  32  read data.
- cfg_ack_o  out  1  slave acknowledge.
- dma_wbs_cyc_o, dma_wbs_stb_o  out  1 each  DMA master request.
- dma_wbs_we_o  out  1  tied 0 (read-only engine).
- dma_wbs_adr_o  out  32  byte address, {9'hF0, addr[22:0]}.
- dma_wbs_dat_i  in  32  read data; valid when dma_wbs_ack_i = 1.
- dma_wbs_ack_i  in  1  read completion.
- dma_brust_valid_i  in  1  SDRAM prefetch-burst hit flag; sampled with ack.
- m_tdata  out  32  stream data.
- m_tvalid, m_tlast  out  1 each  stream valid and last-word marker.
- m_tready  in  1  consumer ready.
- irq_o  out  1  completion interrupt (see Configuration).

## Operation
- Registers:
  - 0x0 CTRL: bit0 START (write-1 pulse), bit1 BUSY (RO), bit2 DONE (write-1-to-clear).
  - 0x4 SRC: byte address [22:0]; bits [1:0] forced 0.
  - 0x8 LEN: words, [LEN_W-1:0].
  - 0xC HITS: RO count of acks with dma_brust_valid_i = 1; cleared on START.
  - Unmapped offsets read 0.
- FSM:
  - IDLE: START with LEN≠0 latches addr←SRC and rem←LEN, clears DONE and HITS, then goes to REQ. START with LEN=0 sets DONE and stays in IDLE with no bus activity. START while BUSY is ignored.
  - REQ: cyc/stb are asserted only when (FIFO count + 1) ≤ FIFO_DEPTH; otherwise the engine stalls in REQ with cyc/stb low. Address and stb stay stable until ack. On ack: push dat_i, addr←addr+4 (wraps mod 2^23, upper 9 bits constant), rem←rem−1. Go to GAP, or to DRAIN if rem was 1.
  - GAP: cyc/stb low for exactly one cycle, then REQ. This lets the SDRAM side's read-valid tracking rearm.
  - DRAIN: wait until the FIFO is empty and the last word has handshaked. Then set DONE and go to IDLE.
- BUSY = state≠IDLE.
- One outstanding request maximum.
- m_tlast is 1 on the word whose fetch was the final one.
- FIFO simultaneous push+pop: count is unchanged, and data order is preserved. Full-without-pop never occurs by the REQ rule.
- HITS saturates at all-ones.
- Reset mid-transfer: FSM→IDLE, FIFO flushed, cyc/stb drop the same edge, registers cleared.

## Timing
- Reset values: all outputs 0; SRC, LEN, HITS, DONE = 0.
- cfg_ack_o: registered, high one cycle after cyc&stb, single-cycle pulse. cfg_dat_o is valid with the ack.
- START→first dma_wbs_stb_o: 1 cycle (IDLE→REQ edge, stb visible in REQ).
- ack→next stb: 2 cycles minimum (GAP).
- ack→m_tvalid: 1 cycle (FIFO registered write, first-word fall-through read).
- Last pop→DONE/BUSY=0: next cycle.

## Configuration
- DMA_IRQ_EN defined: irq_o = DONE & IRQ_MASK, where IRQ_MASK is CTRL bit3 (RW, reset 0). Clearing DONE drops irq_o the next cycle.
- DMA_IRQ_EN undefined: irq_o tied 0, CTRL bit3 reads 0 and ignores writes.

## Structure
- Package dma_burst_pkg holds:
  - register offsets (REG_CTRL/SRC/LEN/HITS);
  - CTRL bit indices;
  - the SDRAM window constant 9'hF0;
  - the FSM state enum {IDLE, REQ, GAP, DRAIN}.
- One sub-module: dma_sfifo, a synchronous first-word-fall-through FIFO with count output, parameterised by width and depth.

## Test plan
- SRC=0x100, LEN=4, m_tready=1, SDRAM acks after 3 cycles -> adr 0x7800_0100/104/108/10C in order, data streamed in order, m_tlast on word 4, DONE=1, BUSY=0.
- LEN=12, FIFO_DEPTH=8, m_tready=0 -> exactly 8 acks then stb stays low. Raise m_tready -> remaining 4 fetched, 12 words total, no loss.
- SRC=0x7F_FFFC, LEN=2 -> second address 0x7800_0000 (23-bit wrap).
- LEN=0 + START -> DONE=1 next cycle, dma_wbs_cyc_o never asserted.
- Assert wb_rst_i while in REQ after 2 of 5 words -> cyc/stb/m_tvalid 0 next cycle, BUSY=0, HITS=0. A fresh START succeeds.
- dma_brust_valid_i high on 3 of 6 acks -> HITS=3. With DMA_IRQ_EN and mask set, irq_o=1 at completion and 0 one cycle after DONE write-1-clear.
